// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, default parameters and helpers for the systolic array
package systolic_pkg;

    localparam int N_PE_DEF   = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int LEN_W_DEF  = 8;
    localparam int SEXT_W     = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_B = 3'd2,
        STREAM = 3'd3,
        FLUSH  = 3'd4,
        DRAIN  = 3'd5
    } state_e;

    // Sign-extends the low w bits of v to the full SEXT_W width.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
        logic signed [SEXT_W-1:0] t;
        t = $signed(v << (SEXT_W - w));
        return t >>> (SEXT_W - w);
    endfunction

endpackage

// File: rtl/systolic_array_seq_if.sv
// rtl/systolic_array_seq_if.sv - job, config, sample and result handshake bundle
// slave: DUT side (start/len, cfg_*, in_*, out_ready in; readies, out_*, busy, done out)
// master: host side (mirror of slave)
interface systolic_array_seq_if #(
    parameter int N_PE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
);
    localparam int IDX_W = $clog2(N_PE);

    logic              start;
    logic [LEN_W-1:0]  len;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, len, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, in_ready, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport master (
        output start, len, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, in_ready, out_valid, out_data, out_idx, out_last, busy, done
    );

endinterface

// File: rtl/systolic_pe_p.sv
// rtl/systolic_pe_p.sv - one MAC processing element with data/valid forwarding
// in: w_we_i/b_we_i + cfg_data_i (weight/bias load), up_data_i/up_valid_i (upstream)
// out: data_o/valid_o (to downstream PE), acc_o (accumulator)
module systolic_pe_p
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_we_i,
    input  logic              b_we_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic              up_valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic [DATA_W-1:0]          weight_q;
    logic [DATA_W-1:0]          data_q;
    logic                       valid_q;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic signed [2*DATA_W-1:0] prod;

    // Both operands widened to the product width so the multiply is full-precision signed.
    assign prod = $signed({{DATA_W{up_data_i[DATA_W-1]}}, up_data_i})
                * $signed({{DATA_W{weight_q[DATA_W-1]}}, weight_q});

    always_comb begin
        acc_d = acc_q;
        if (b_we_i) begin
            acc_d = ACC_W'(sext(SEXT_W'(cfg_data_i), DATA_W));
        end else if (up_valid_i) begin
            acc_d = acc_q + ACC_W'(sext(SEXT_W'(prod), 2 * DATA_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            acc_q    <= '0;
        end else begin
            if (w_we_i) begin
                weight_q <= cfg_data_i;
            end
            data_q  <= up_data_i;
            valid_q <= up_valid_i;
            acc_q   <= acc_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_array_seq.sv
// rtl/systolic_array_seq.sv - self-sequencing weight-stationary MAC chain
// ports: clk, rst_n (async, active-low), bus (slave modport: job start/len,
// cfg stream, sample stream, result stream with out_idx/out_last, busy, done)
module systolic_array_seq
    import systolic_pkg::*;
#(
    parameter int N_PE   = N_PE_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_array_seq_if.slave  bus
);

    localparam int IDX_W = $clog2(N_PE);
    // One counter serves cfg beats, samples and flush cycles.
    localparam int CW    = (LEN_W > IDX_W) ? LEN_W : IDX_W;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    logic cfg_fire, in_fire, out_fire, last_beat;

    logic [DATA_W-1:0] chain_data  [N_PE+1];
    logic              chain_valid [N_PE+1];
    logic [ACC_W-1:0]  acc         [N_PE];

    assign cfg_fire  = bus.cfg_valid && bus.cfg_ready;
    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_beat = (cnt_q == CW'(N_PE - 1));

    // Chain head: a non-accepted cycle enters PE0 as a bubble.
    assign chain_data[0]  = bus.in_data;
    assign chain_valid[0] = in_fire;

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        systolic_pe_p #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk        (clk),
            .rst_n      (rst_n),
            .w_we_i     (cfg_fire && state_q == LOAD_W && cnt_q == CW'(k)),
            .b_we_i     (cfg_fire && state_q == LOAD_B && cnt_q == CW'(k)),
            .cfg_data_i (bus.cfg_data),
            .up_data_i  (chain_data[k]),
            .up_valid_i (chain_valid[k]),
            .data_o     (chain_data[k+1]),
            .valid_o    (chain_valid[k+1]),
            .acc_o      (acc[k])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (cfg_fire) begin
                    cnt_d = last_beat ? '0 : cnt_q + CW'(1);
                    if (last_beat) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (cfg_fire) begin
                    cnt_d = last_beat ? '0 : cnt_q + CW'(1);
                    if (last_beat) state_d = (len_q == '0) ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                if (in_fire) begin
                    if (cnt_q + CW'(1) == CW'(len_q)) begin
                        cnt_d   = '0;
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                // N_PE cycles lets the final sample reach the last PE.
                cnt_d = last_beat ? '0 : cnt_q + CW'(1);
                if (last_beat) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    if (idx_q == IDX_W'(N_PE - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.cfg_ready = (state_q == LOAD_W) || (state_q == LOAD_B);
    assign bus.in_ready  = (state_q == STREAM);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = (state_q == DRAIN) && (idx_q == IDX_W'(N_PE - 1));
    assign bus.out_data  = (state_q == DRAIN) ? acc[idx_q] : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_array_seq.sv
// tb/tb_systolic_array_seq.sv - scoreboard bench for systolic_array_seq
module tb_systolic_array_seq;

    localparam int N = 4;

    logic clk;
    logic rst_n;

    systolic_array_seq_if #(.N_PE(N), .DATA_W(8), .ACC_W(16), .LEN_W(8)) bus ();

    systolic_array_seq #(.N_PE(N), .DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          idx;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   w_a[N];
    int   b_a[N];
    int   samp[$];
    int   in_ready_seen = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total_cnt++;
        if (act !== req) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        else pass_cnt++;
    endtask

    function automatic int s8(input int v);
        return (v & 8'h80) != 0 ? (v & 8'hFF) - 256 : (v & 8'hFF);
    endfunction

    // Reference: every PE ends at bias + weight * (sum of samples), modulo 2^16.
    task automatic push_expected();
        int sum;
        exp_t e;
        sum = 0;
        foreach (samp[i]) sum += s8(samp[i]);
        for (int k = 0; k < N; k++) begin
            e.d    = 16'((s8(b_a[k]) + s8(w_a[k]) * sum) & 32'hFFFF);
            e.idx  = k;
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops on every transfer and checks holding while stalled.
    logic        hold;
    logic [15:0] hold_d;
    int          hold_i;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (bus.in_ready) in_ready_seen++;
            if (bus.out_valid && hold) begin
                chk("stall_data_stable", bus.out_data, hold_d);
                chk("stall_idx_stable", bus.out_idx, hold_i);
            end
            hold = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_idx", bus.out_idx, e.idx);
                    chk("out_last", bus.out_last, e.last);
                end
            end else if (bus.out_valid) begin
                hold   = 1'b1;
                hold_d = bus.out_data;
                hold_i = int'(bus.out_idx);
            end
        end
    end

    task automatic do_start(input int len);
        int n = 0;
        while (bus.busy && n < 2000) begin @(posedge clk); #1; n++; end
        if (n == 2000) chk("idle_timeout", 0, 1);
        bus.start = 1'b1;
        bus.len   = 8'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.len   = 8'($urandom_range(255));
        chk("busy_after_start", bus.busy, 1);
        chk("cfg_ready_after_start", bus.cfg_ready, 1);
    endtask

    task automatic do_cfg();
        for (int k = 0; k < 2 * N; k++) begin
            int n = 0;
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = 8'(k < N ? w_a[k] : b_a[k - N]);
            while (!bus.cfg_ready && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) chk("cfg_timeout", 0, 1);
            @(posedge clk); #1;
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic do_sample(input int v, input bit bub);
        int n = 0;
        if (bub) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(v);
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) chk("in_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input bit bub, input bit stall);
        int n = 0;
        int sc = 0;
        push_expected();
        bus.out_ready = !stall;
        do_start(samp.size());
        do_cfg();
        foreach (samp[i]) do_sample(samp[i], bub);
        while (!bus.done && n < 2000) begin
            @(posedge clk); #1; n++;
            if (stall) begin
                if (bus.out_ready) begin
                    bus.out_ready = 1'b0;
                    sc = 0;
                end else if (bus.out_valid) begin
                    sc++;
                    if (sc >= 3) bus.out_ready = 1'b1;
                end
            end
        end
        chk("done_seen", bus.done, 1);
        chk("busy_with_done", bus.busy, 0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic set_basic();
        for (int k = 0; k < N; k++) begin w_a[k] = k + 1; b_a[k] = 0; end
        samp = '{1, 2, 3};
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0;
        bus.cfg_valid = 1'b0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_data", bus.out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_basic();
        run_job(0, 0);

        for (int k = 0; k < N; k++) begin w_a[k] = $urandom_range(255); b_a[k] = $urandom_range(255); end
        w_a[0] = 8'hFF; b_a[0] = 5; samp = '{8'h7F, 8'h7F, 8'h7F};
        run_job(0, 0);

        w_a[0] = 8'h7F; b_a[0] = 0;
        run_job(0, 0);

        b_a = '{8'h80, 1, 2, 3}; samp = {};
        in_ready_seen = 0;
        run_job(0, 0);
        chk("len0_no_in_ready", in_ready_seen, 0);

        set_basic();
        run_job(1, 1);

        for (int j = 0; j < 5; j++) begin
            int l = $urandom_range(20);
            for (int k = 0; k < N; k++) begin w_a[k] = $urandom_range(255); b_a[k] = $urandom_range(255); end
            samp = {};
            for (int i = 0; i < l; i++) samp.push_back($urandom_range(255));
            run_job(1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        // Abort a job in STREAM; nothing is pushed so any result is flagged.
        for (int k = 0; k < N; k++) begin w_a[k] = 9; b_a[k] = 7; end
        do_start(3);
        do_cfg();
        do_sample(5, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        chk("abort_busy_edge", bus.busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_basic();
        run_job(0, 0);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
